// File: rtl/seq_divider.sv
// Restoring sequential divider: one quotient bit per clock, signed or unsigned per operation,
// divide-by-zero flagged. Valid/ready on both sides; operations never overlap.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             zdiv_q, zdiv_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             sgn_a, sgn_b;

  // Unsigned negation, so |MIN| = 2^(WIDTH-1) still fits in WIDTH bits.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    zdiv_d      = zdiv_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    sgn_a     = signed_op & dividend[WIDTH-1];
    sgn_b     = signed_op & divisor[WIDTH-1];
    rem_sh    = {rem_q, quo_q[WIDTH-1]};
    diff      = rem_sh - {1'b0, dvs_q};
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          negq_d  = sgn_a ^ sgn_b;
          negr_d  = sgn_a;
          dvs_d   = cond_neg(divisor, sgn_b);
          rem_d   = '0;
          state_d = CALC;
          // A zero divisor skips the iterations; quo carries the raw dividend to the result.
          if (divisor == '0) begin
            zdiv_d = 1'b1;
            quo_d  = dividend;
            cnt_d  = '0;
          end else begin
            zdiv_d = 1'b0;
            quo_d  = cond_neg(dividend, sgn_a);
            cnt_d  = CNT_INIT;
          end
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (zdiv_q) begin
            quotient_d  = '1;
            remainder_d = quo_q;
            dbz_d       = 1'b1;
          end else begin
            quotient_d  = cond_neg(quo_q, negq_q);
            remainder_d = cond_neg(rem_q, negr_q);
            dbz_d       = 1'b0;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Working registers are always reloaded on accept, so they need no reset.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    dvs_q  <= dvs_d;
    negq_q <= negq_d;
    negr_q <= negr_d;
    zdiv_q <= zdiv_d;
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule
